// File: rtl/bitcoin_pkg.sv
// Shared definitions for the nonce-scan post-processor: FSM states, default scan
// length and the layout of the 3-word result record.
package bitcoin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } scan_state_t;

    localparam int NUM_NONCES_DEFAULT = 16;

    localparam logic [1:0] RES_HASH  = 2'd0;
    localparam logic [1:0] RES_NONCE = 2'd1;
    localparam logic [1:0] RES_STAT  = 2'd2;

    function automatic logic [31:0] status_word(input logic found, input logic [7:0] hit_count);
        return {found, 23'b0, hit_count};
    endfunction

endpackage

// File: rtl/bitcoin_nonce_scan_accumulator.sv
// Running minimum / hit counter over a stream of hash words, one per valid strobe.
// Ties keep the earlier index because the minimum update uses a strict compare.
module scan_accumulator (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [31:0] hash,
    input  logic [7:0]  index,
    input  logic [31:0] target,
    output logic        found,
    output logic [7:0]  hit_count,
    output logic [31:0] best_nonce,
    output logic [31:0] best_hash
);

    logic        found_reg;
    logic [7:0]  hit_count_reg;
    logic [31:0] best_nonce_reg;
    logic [31:0] best_hash_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found_reg      <= 1'b0;
            hit_count_reg  <= 8'd0;
            best_nonce_reg <= 32'd0;
            best_hash_reg  <= 32'd0;
        end else if (clear) begin
            found_reg      <= 1'b0;
            hit_count_reg  <= 8'd0;
            best_nonce_reg <= 32'd0;
            best_hash_reg  <= 32'hFFFF_FFFF;
        end else if (valid) begin
            if (hash < target) begin
                hit_count_reg <= hit_count_reg + 8'd1;
                found_reg     <= 1'b1;
            end
            if (hash < best_hash_reg) begin
                best_hash_reg  <= hash;
                best_nonce_reg <= {24'd0, index};
            end
        end
    end

    assign found      = found_reg;
    assign hit_count  = hit_count_reg;
    assign best_nonce = best_nonce_reg;
    assign best_hash  = best_hash_reg;

endmodule

// File: rtl/bitcoin_nonce_scan.sv
// Reads NUM_NONCES hash words back from shared memory, tracks the minimum and the
// below-target count, then writes a 3-word result record and returns to idle.
module bitcoin_nonce_scan
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  hit_count,
    output logic [31:0] best_nonce,
    output logic [31:0] best_hash
);

    localparam logic [8:0] RD_LAST = 9'(NUM_NONCES);

    scan_state_t state_reg, state_next;
    logic [15:0] base_reg, base_next;
    logic [15:0] offset_reg, offset_next;
    logic [8:0]  rd_cnt_reg, rd_cnt_next;
    logic [1:0]  wr_idx_reg, wr_idx_next;

    logic        acc_clear;
    logic        acc_valid;
    logic [7:0]  acc_index;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            base_reg   <= 16'd0;
            offset_reg <= 16'd0;
            rd_cnt_reg <= 9'd0;
            wr_idx_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            base_reg   <= base_next;
            offset_reg <= offset_next;
            rd_cnt_reg <= rd_cnt_next;
            wr_idx_reg <= wr_idx_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        offset_next = offset_reg;
        rd_cnt_next = rd_cnt_reg;
        wr_idx_next = wr_idx_reg;
        acc_clear   = 1'b0;
        acc_valid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    base_next   = input_addr;
                    offset_next = 16'd0;
                    rd_cnt_next = 9'd0;
                    acc_clear   = 1'b1;
                    state_next  = ST_READ;
                end
            end
            ST_READ: begin
                // Read data lags the address by one cycle, so cycle k processes hash k-1.
                acc_valid = (rd_cnt_reg != 9'd0);
                if (rd_cnt_reg < RD_LAST) begin
                    offset_next = offset_reg + 16'd1;
                end
                rd_cnt_next = rd_cnt_reg + 9'd1;
                if (rd_cnt_reg == RD_LAST) begin
                    base_next   = result_addr;
                    offset_next = 16'd0;
                    wr_idx_next = 2'd0;
                    state_next  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                offset_next = offset_reg + 16'd1;
                wr_idx_next = wr_idx_reg + 2'd1;
                if (wr_idx_reg == RES_STAT) begin
                    wr_idx_next = 2'd0;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign acc_index = 8'(rd_cnt_reg - 9'd1);

    scan_accumulator u_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (acc_clear),
        .valid      (acc_valid),
        .hash       (mem_read_data),
        .index      (acc_index),
        .target     (target),
        .found      (found),
        .hit_count  (hit_count),
        .best_nonce (best_nonce),
        .best_hash  (best_hash)
    );

    // Write enable decoded from state so it falls together with an async reset.
    always_comb begin
        mem_write_data = 32'd0;
        if (state_reg == ST_WRITE) begin
            case (wr_idx_reg)
                RES_HASH:  mem_write_data = best_hash;
                RES_NONCE: mem_write_data = best_nonce;
                RES_STAT:  mem_write_data = status_word(found, hit_count);
                default:   mem_write_data = 32'd0;
            endcase
        end
    end

    assign done     = (state_reg == ST_IDLE);
    assign mem_we   = (state_reg == ST_WRITE);
    assign mem_addr = base_reg + offset_reg;
    assign mem_clk  = clk;

endmodule

// File: tb/tb_bitcoin_nonce_scan.sv
// Table-driven and randomized bench for bitcoin_nonce_scan with a memory model
// and a behavioural reference computed directly from the scan rules.
module tb_bitcoin_nonce_scan;

    localparam int N  = 16;
    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] input_addr = 16'd0;
    logic [15:0] result_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        found;
    logic [7:0]  hit_count;
    logic [31:0] best_nonce;
    logic [31:0] best_hash;

    bitcoin_nonce_scan #(.NUM_NONCES(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .input_addr     (input_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .found          (found),
        .hit_count      (hit_count),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read from mem, writes captured in a log only.
    logic [31:0] mem [0:65535];
    logic [47:0] wr_log [$];

    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) wr_log.push_back({mem_addr, mem_write_data});
    end

    typedef struct {
        int          kind;
        logic [15:0] in_addr;
        logic [15:0] res_addr;
        logic [31:0] tgt;
        logic        exp_found;
        logic [7:0]  exp_cnt;
        logic [31:0] exp_nonce;
        logic [31:0] exp_hash;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] vh [NV][N];

    logic [31:0] cur_h [N];
    logic [15:0] cur_in, cur_res;
    logic [31:0] cur_tgt;
    logic        exp_found;
    logic [7:0]  exp_cnt;
    logic [31:0] exp_nonce, exp_hash;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: minimum with earliest index, count of strictly-below-target words.
    task automatic model(input int v);
        logic [31:0] best;
        logic [31:0] idx;
        int          cnt;
        best = 32'hFFFF_FFFF;
        idx  = 32'd0;
        cnt  = 0;
        for (int i = 0; i < N; i++) begin
            if (vh[v][i] < vecs[v].tgt) cnt++;
            if (vh[v][i] < best) begin
                best = vh[v][i];
                idx  = i;
            end
        end
        vecs[v].exp_found = (cnt > 0);
        vecs[v].exp_cnt   = 8'(cnt);
        vecs[v].exp_nonce = idx;
        vecs[v].exp_hash  = best;
    endtask

    task automatic gen_hashes(input int v);
        int mode;
        for (int i = 0; i < N; i++) begin
            case (vecs[v].kind)
                0: vh[v][i] = 32'hF000_0000 - 32'(i) * 32'h0100_0000;
                1: vh[v][i] = 32'h1234_5678;
                2: vh[v][i] = (i == 5) ? 32'h0000_0100 : 32'hFFFF_FFFF;
                default: begin
                    mode = $urandom_range(0, 2);
                    if (mode == 0)      vh[v][i] = $urandom;
                    else if (mode == 1) vh[v][i] = $urandom_range(0, 7);
                    else                vh[v][i] = $urandom & 32'h0000_FFFF;
                end
            endcase
        end
    endtask

    task automatic set_vec(input int v);
        for (int i = 0; i < N; i++) cur_h[i] = vh[v][i];
        cur_in    = vecs[v].in_addr;
        cur_res   = vecs[v].res_addr;
        cur_tgt   = vecs[v].tgt;
        exp_found = vecs[v].exp_found;
        exp_cnt   = vecs[v].exp_cnt;
        exp_nonce = vecs[v].exp_nonce;
        exp_hash  = vecs[v].exp_hash;
    endtask

    task automatic load_mem();
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            a = cur_in + 16'(i);
            mem[a] = cur_h[i];
        end
        // The word past the last hash must be ignored; make it an attractive minimum.
        a = cur_in + 16'(N);
        mem[a] = 32'd0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is back high.
    task automatic do_scan(input bit hold, input string tag);
        int          low;
        int          we;
        int          wstart;
        logic [15:0] rd_addr [$];
        logic [15:0] ea;
        low    = 0;
        we     = 0;
        wstart = wr_log.size();
        input_addr  = cur_in;
        result_addr = cur_res;
        target      = cur_tgt;
        start       = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check({tag, "_accept"}, 32'(done), 32'd0);
        check({tag, "_clr_hash"}, best_hash, 32'hFFFF_FFFF);
        check({tag, "_clr_cnt"}, 32'({found, hit_count}), 32'd0);
        while (done == 1'b0 && low < 200) begin
            low++;
            if (mem_we) begin
                we++;
                if (we == 1) check({tag, "_wr0_hash"}, best_hash, exp_hash);
            end else begin
                rd_addr.push_back(mem_addr);
            end
            @(negedge clk);
        end
        check({tag, "_done_low"}, 32'(low), 32'(N + 4));
        check({tag, "_we_cycles"}, 32'(we), 32'd3);
        check({tag, "_rd_count"}, 32'(rd_addr.size()), 32'(N + 1));
        for (int i = 0; i < rd_addr.size() && i <= N; i++) begin
            ea = cur_in + 16'(i);
            check({tag, "_rd_addr"}, 32'(rd_addr[i]), 32'(ea));
        end
        check({tag, "_found"}, 32'(found), 32'(exp_found));
        check({tag, "_hits"}, 32'(hit_count), 32'(exp_cnt));
        check({tag, "_nonce"}, best_nonce, exp_nonce);
        check({tag, "_hash"}, best_hash, exp_hash);
        check({tag, "_wr_count"}, 32'(wr_log.size() - wstart), 32'd3);
        if (wr_log.size() >= wstart + 3) begin
            for (int k = 0; k < 3; k++) begin
                ea = cur_res + 16'(k);
                check({tag, "_wr_addr"}, 32'(wr_log[wstart + k][47:32]), 32'(ea));
            end
            check({tag, "_rec_hash"}, wr_log[wstart][31:0], exp_hash);
            check({tag, "_rec_nonce"}, wr_log[wstart + 1][31:0], exp_nonce);
            check({tag, "_rec_stat"}, wr_log[wstart + 2][31:0], {exp_found, 23'd0, exp_cnt});
        end
        $display("scan %s: in=%h res=%h target=%h -> found=%0d hits=%0d nonce=%0d hash=%h",
                 tag, cur_in, cur_res, cur_tgt, found, hit_count, best_nonce, best_hash);
    endtask

    initial begin
        int wstart;

        vecs[0] = '{0, 16'h0100, 16'h2000, 32'd1,          1'b0, 8'd0,  32'd15, 32'hE100_0000};
        vecs[1] = '{1, 16'h0200, 16'h2010, 32'h1234_5679,  1'b1, 8'd16, 32'd0,  32'h1234_5678};
        vecs[2] = '{2, 16'h0300, 16'h2020, 32'h0000_0100,  1'b0, 8'd0,  32'd5,  32'h0000_0100};
        vecs[3] = '{3, 16'hFFF8, 16'h2030, 32'd0, 1'b0, 8'd0, 32'd0, 32'd0};
        for (int v = 4; v < NV; v++) begin
            vecs[v] = '{3, 16'($urandom), 16'h3000 + 16'(v * 4), 32'd0, 1'b0, 8'd0, 32'd0, 32'd0};
        end
        for (int v = 0; v < NV; v++) begin
            gen_hashes(v);
            if (vecs[v].kind == 3) begin
                vecs[v].tgt = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8));
                model(v);
            end
        end

        // Reset state
        #1;
        check("rst_async_done", 32'(done), 32'd1);
        check("rst_async_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_results", 32'({found, hit_count}), 32'd0);
        check("rst_nonce", best_nonce, 32'd0);
        check("rst_hash", best_hash, 32'd0);

        for (int v = 0; v < NV; v++) begin
            set_vec(v);
            load_mem();
            do_scan(1'b0, $sformatf("vec%0d", v));
            @(negedge clk);
        end

        // Reset asserted during READ cycle 7, then a clean rerun.
        set_vec(4);
        load_mem();
        wstart      = wr_log.size();
        input_addr  = cur_in;
        result_addr = cur_res;
        target      = cur_tgt;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_results", 32'({found, hit_count}), 32'd0);
        check("midrst_hash", best_hash, 32'd0);
        check("midrst_nonce", best_nonce, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_no_record", 32'(wr_log.size() - wstart), 32'd0);
        do_scan(1'b0, "after_rst");
        @(negedge clk);

        // start held high: second scan accepted on the first idle cycle with new data.
        set_vec(5);
        load_mem();
        do_scan(1'b1, "held_a");
        set_vec(6);
        load_mem();
        do_scan(1'b0, "held_b");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bitcoin_nonce_scan.md
# bitcoin_nonce_scan

Post-processing block for the nonce search: after the hashing engine has written one 32-bit final-hash word (H0) per nonce into shared memory, this block reads those NUM_NONCES words back over the same single-port memory interface. It selects the smallest hash and counts hashes strictly below a difficulty target. It writes a 3-word result record to memory and holds the summary on output ports. It sits after the hashing engine on the same memory bus; bus arbitration between the two blocks is the top level's responsibility.

## Interface
- NUM_NONCES, 16, number of hash words to scan; legal range 1..255.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  starts a scan; sampled only in IDLE.
- input_addr  in  16  word address of hash for nonce 0; hash i is at input_addr+i.
- result_addr  in  16  word address of the 3-word result record.
- target  in  32  difficulty threshold; a hit is hash < target, unsigned.
- done  out  1  high exactly when in IDLE.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  word address, = base_reg + offset_reg, mod 2^16.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  synchronous-read data; the word addressed in cycle t is valid for capture at the end of cycle t+1.
- found  out  1  at least one hit.
- hit_count  out  8  number of hits.
- best_nonce  out  32  index of the minimum hash, zero-extended.
- best_hash  out  32  minimum hash value.

## Operation
- States: IDLE, READ, WRITE.
- IDLE, start=1: latch base_reg=input_addr, offset_reg=0, rd_cnt=0; clear found, hit_count, best_nonce; set best_hash=32'hFFFF_FFFF; go to READ. start=0: hold.
- READ, each cycle:
  - if rd_cnt>0, process mem_read_data as hash (rd_cnt-1).
  - if rd_cnt<NUM_NONCES, offset_reg++.
  - rd_cnt++.
  - when rd_cnt==NUM_NONCES, do the final capture, then set base_reg=result_addr, offset_reg=0, wr_idx=0, mem_we=1, go to WRITE.
- Process hash x with index n:
  - if x<target, hit_count++ and found=1.
  - if x<best_hash, best_hash=x and best_nonce=n. The comparison is strict, so ties keep the lowest index.
- The last READ cycle addresses input_addr+NUM_NONCES. The returned data is ignored.
- WRITE: mem_write_data is a combinational mux on wr_idx:
  - 0: best_hash
  - 1: best_nonce
  - 2: {found, 23'b0, hit_count}
- WRITE advance: offset_reg++ and wr_idx++ each cycle. After wr_idx==2: mem_we=0, go to IDLE.
- Result ports hold their values until the next accepted start.
- start while busy is ignored. start held high re-triggers on the first IDLE cycle.

## Timing
- Reset values:
  - state IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0.
  - found=0, hit_count=0, best_nonce=0, best_hash=0.
- Latency from the start-accepting edge: READ lasts NUM_NONCES+1 cycles, WRITE lasts 3 cycles. done is low for NUM_NONCES+4 cycles (20 at default).
- mem_we is high for exactly the 3 WRITE cycles. Addresses are consecutive.
- The hash captured at the last READ edge is reflected in best_*/hit_count in WRITE cycle 0.
- Address wrap: input_addr=16'hFFFE reads FFFE, FFFF, 0000, ...
- Reset mid-operation: immediate return to reset values. mem_we drops asynchronously, and no partial record completes.

## Structure
- Shared package bitcoin_pkg holds:
  - state enum.
  - NUM_NONCES default.
  - result-record offsets RES_HASH=0, RES_NONCE=1, RES_STAT=2.
- Sub-module scan_accumulator: compare/min/count logic, with clear and valid-strobe inputs. The FSM and memory sequencing stay in the top.

## Test plan
- Hash i = 32'hF000_0000 - i*32'h0100_0000, target=1 -> found=0, hit_count=0, best_nonce=15, best_hash=32'hE100_0000. Record written: E1000000, 0000000F, 00000000.
- All hashes 32'h12345678, target 32'h12345679 -> hit_count=16, found=1, best_nonce=0, status word 32'h80000010.
- Hash 5 = 32'h00000100, others 32'hFFFFFFFF, target 32'h00000100 -> found=0 (strict compare), best_nonce=5, best_hash=32'h00000100.
- Single start pulse, input_addr=16'hFFF8 -> reads FFF8..0007 in order. done low for exactly 20 cycles. mem_we high for exactly 3 cycles, at result_addr..+2.
- reset_n asserted in READ cycle 7 -> done=1, mem_we=0, results zero. Next start then yields a correct full scan.
- start held high through completion -> second scan begins on the first IDLE cycle. Results are cleared at acceptance and match the rerun data.
